nkmm_prog_arb: RTL
==================

// Module: nkmm_prog_arb
// PURPOSE
//  Arbiter sharing one synchronous single-port program RAM between the nkmm_cpu fetch port and a host port.
//  The host port handles program download and readback.
//  Host has priority; a starvation limiter guarantees CPU fetch progress.
//  host_lock_i drains any outstanding CPU fetch, then stalls the CPU while the host owns the RAM exclusively.
//  Sits between nkmm_cpu (prog_addr_o / prog_data_i) and the program RAM macro.
// PARAMETERS
//  AW            `PROG_ADDR_WIDTH (10)  program RAM address width
//  DW            `INSN_WIDTH (32)       instruction word width
//  STARVE_LIMIT  4                      max consecutive host grants while cpu_req_i is pending (RUN state only); >=1
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   asynchronous active-low reset (asserted when 0)
//  cpu_req_i      in   1   CPU fetch request; CPU holds cpu_addr_i stable while cpu_stall_o=1
//  cpu_addr_i     in   AW  fetch address
//  cpu_stall_o    out  1   request not granted this cycle (combinational)
//  cpu_valid_o    out  1   fetch data valid (1 cycle after grant)
//  cpu_data_o     out  DW  fetched instruction; holds last fetched word when cpu_valid_o=0
//  host_req_i     in   1   host access request; req/we/addr/wdata held until host_ack_o
//  host_we_i      in   1   1=write, 0=read
//  host_addr_i    in   AW  host address
//  host_wdata_i   in   DW  host write data
//  host_lock_i    in   1   request exclusive RAM ownership
//  host_ack_o     out  1   host request granted this cycle (combinational)
//  host_locked_o  out  1   registered; 1 in LOCKED state
//  host_rvalid_o  out  1   host read data valid (1 cycle after read grant)
//  host_rdata_o   out  DW  host read data (= mem_rdata_i, qualified by host_rvalid_o)
//  mem_en_o       out  1   RAM access strobe (combinational from grant)
//  mem_we_o       out  1   RAM write enable
//  mem_addr_o     out  AW  RAM address
//  mem_wdata_o    out  DW  RAM write data
//  mem_rdata_i    in   DW  RAM read data, valid 1 cycle after mem_en_o & ~mem_we_o
// BEHAVIOUR
//  - At most one RAM access per cycle.
//  - Grants are combinational from current requests and state; mem_* = granted source's fields, else mem_en_o=0.
//  - States (registered): RUN, DRAIN, LOCKED.
//  - RUN
//    - host_req_i wins, unless starve_cnt==STARVE_LIMIT and cpu_req_i=1; then the CPU is granted.
//    - starve_cnt increments on each host grant while cpu_req_i=1.
//    - starve_cnt clears on any CPU grant or when cpu_req_i=0; it saturates at STARVE_LIMIT.
//    - host_lock_i=1: go to DRAIN if a CPU read is outstanding next cycle (granted this cycle), else to LOCKED.
//  - DRAIN: no CPU grants; host grants allowed; go to LOCKED when the outstanding CPU return completes (always 1 cycle).
//  - LOCKED
//    - CPU never granted; cpu_stall_o = cpu_req_i; host granted every requesting cycle.
//    - host_lock_i=0: go to RUN with starve_cnt=0.
//  - Read latency: grant in cycle N -> cpu_valid_o or host_rvalid_o=1 in cycle N+1 with data = mem_rdata_i.
//    - A 1-bit return-source register tracks the destination; host writes produce no return.
//  - cpu_data_o: mem_rdata_i when cpu_valid_o=1, else a hold register updated on every cpu_valid_o.
//  - Same-cycle host write and CPU fetch to the same address: host write wins.
//    - The CPU fetch is stalled and reads the new word when granted.
//  - host_lock_i deasserted while in DRAIN: complete the drain, enter LOCKED for 1 cycle, then RUN.
//  - Reset values
//    - state=RUN, starve_cnt=0, return-source=none, hold reg=0.
//    - cpu_valid_o=0, host_rvalid_o=0, host_locked_o=0, cpu_data_o=0.
//    - Combinational outputs follow from the zeroed state.
//  - Reset mid-operation: any in-flight read return is discarded (no valid pulse after rst deasserts).
// STRUCTURE
//  - nkmm_const.v gains `PROG_ADDR_WIDTH and the state encodings `PARB_RUN=2'd0, `PARB_DRAIN=2'd1, `PARB_LOCKED=2'd2.
//  - `INSN_WIDTH is reused from nkmm_const.v.
//  - No sub-module: state register, starvation counter and return tracker are inline; memory model lives in the bench.
// TESTING
//  1. Reset: rst=0 for 3 cycles with cpu_req_i=1 -> all registered outputs 0, no mem_en_o until rst=1.
//     After release, the first fetch of addr 0 returns the RAM word the next cycle.
//  2. CPU only: fetch addr 0,1,2 back-to-back, RAM preloaded 32'h11,22,33.
//     -> cpu_valid_o on 3 consecutive cycles with those words; cpu_stall_o=0 throughout.
//  3. Starvation: host_req_i held continuously for writes, cpu_req_i=1, STARVE_LIMIT=4.
//     -> 4 host acks, then 1 CPU grant, repeating; the CPU never waits more than 4 cycles.
//  4. Collision: host write 32'hDEAD to addr 5 and CPU fetch of addr 5 in the same cycle.
//     -> host_ack_o=1, cpu_stall_o=1; the next cycle's CPU grant returns 32'hDEAD.
//  5. Lock with outstanding fetch: CPU granted and host_lock_i=1 in cycle N.
//     -> DRAIN in N+1 (cpu_valid_o=1), LOCKED with host_locked_o=1 in N+2, cpu_stall_o=1.
//     Host writes words 0..15; lock release -> RUN, and CPU fetches read the new words.
//  6. Reset mid-read: host read granted, then rst=0 in the next cycle -> host_rvalid_o stays 0 and state=RUN.

Source files
------------

// File: rtl/nkmm_prog_arb_pkg.sv
// Shared types and constants for the nkmm program-RAM arbiter.
package nkmm_prog_arb_pkg;

  localparam int PROG_ADDR_WIDTH = 10;
  localparam int INSN_WIDTH      = 32;

  // Arbiter ownership states.
  typedef enum logic [1:0] {
    PARB_RUN    = 2'd0,
    PARB_DRAIN  = 2'd1,
    PARB_LOCKED = 2'd2
  } parb_state_e;

  // Destination of the RAM read data that returns next cycle.
  typedef enum logic [1:0] {
    RET_NONE = 2'd0,
    RET_CPU  = 2'd1,
    RET_HOST = 2'd2
  } ret_src_e;

  // At most one of the two fields is ever set.
  typedef struct packed {
    logic cpu;
    logic host;
  } grant_t;

  // Where a grant issued this cycle sends its read data; host writes return nothing.
  function automatic ret_src_e ret_src(input grant_t gnt, input logic host_we);
    if (gnt.cpu)                 return RET_CPU;
    else if (gnt.host && !host_we) return RET_HOST;
    else                         return RET_NONE;
  endfunction

endpackage

// File: rtl/nkmm_prog_arb_if.sv
// CPU fetch port, host port and RAM macro port of the program-RAM arbiter.
interface nkmm_prog_arb_if
  import nkmm_prog_arb_pkg::*;
#(
  parameter int AW = PROG_ADDR_WIDTH,
  parameter int DW = INSN_WIDTH
) ();

  // CPU fetch port
  logic          cpu_req_i;
  logic [AW-1:0] cpu_addr_i;
  logic          cpu_stall_o;
  logic          cpu_valid_o;
  logic [DW-1:0] cpu_data_o;

  // Host download / readback port
  logic          host_req_i;
  logic          host_we_i;
  logic [AW-1:0] host_addr_i;
  logic [DW-1:0] host_wdata_i;
  logic          host_lock_i;
  logic          host_ack_o;
  logic          host_locked_o;
  logic          host_rvalid_o;
  logic [DW-1:0] host_rdata_o;

  // Program RAM macro port
  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  // Arbiter side.
  modport slave (
    input  cpu_req_i, cpu_addr_i,
    input  host_req_i, host_we_i, host_addr_i, host_wdata_i, host_lock_i,
    input  mem_rdata_i,
    output cpu_stall_o, cpu_valid_o, cpu_data_o,
    output host_ack_o, host_locked_o, host_rvalid_o, host_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  // Environment side: CPU, host and RAM macro.
  modport master (
    output cpu_req_i, cpu_addr_i,
    output host_req_i, host_we_i, host_addr_i, host_wdata_i, host_lock_i,
    output mem_rdata_i,
    input  cpu_stall_o, cpu_valid_o, cpu_data_o,
    input  host_ack_o, host_locked_o, host_rvalid_o, host_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/nkmm_prog_arb.sv
// Shares one single-port program RAM between the nkmm_cpu fetch port and a
// host download/readback port. Host has priority, a starvation counter forces
// a CPU grant after STARVE_LIMIT consecutive host wins, and host_lock_i gives
// the host exclusive ownership once any CPU fetch in flight has returned.
module nkmm_prog_arb
  import nkmm_prog_arb_pkg::*;
#(
  parameter int AW           = PROG_ADDR_WIDTH,
  parameter int DW           = INSN_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,   // asynchronous, active low
  nkmm_prog_arb_if.slave  bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  parb_state_e   state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  ret_src_e      ret_q, ret_d;
  logic [DW-1:0] hold_q;
  grant_t        gnt;
  logic          starved;
  logic [AW-1:0] sel_addr;

  assign starved = (starve_cnt_q == CW'(STARVE_LIMIT));

  // Grant decision: combinational from current requests and state.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
    gnt = '0;
    // NOTE: grants are gated by the asynchronous reset itself, so no RAM strobe escapes while rst is held low.
    if (rst) begin
      case (state_q)
        PARB_RUN: begin
          gnt.cpu  = bus.cpu_req_i & (~bus.host_req_i | starved);
          gnt.host = bus.host_req_i & ~gnt.cpu;
        end
        PARB_DRAIN, PARB_LOCKED: begin
          gnt.host = bus.host_req_i;
        end
        default: gnt = '0;
      endcase
    end
  end

  // Next state and starvation count; the counter only runs in RUN.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = '0;
    case (state_q)
      PARB_RUN: begin
        if (bus.cpu_req_i && gnt.host) begin
          starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + CW'(1);
        end
        if (bus.host_lock_i) begin
          state_d = gnt.cpu ? PARB_DRAIN : PARB_LOCKED;
        end
      end
      PARB_DRAIN: begin
        // The outstanding CPU return always completes in this cycle.
        state_d = PARB_LOCKED;
      end
      PARB_LOCKED: begin
        if (!bus.host_lock_i) state_d = PARB_RUN;
      end
      default: state_d = PARB_RUN;
    endcase
  end

  // Return tracker: remembers who receives the read data next cycle.
  always_comb begin
    ret_d = ret_src(gnt, bus.host_we_i);
  end

  // State, counter and return-tracker registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q      <= PARB_RUN;
      starve_cnt_q <= '0;
      ret_q        <= RET_NONE;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      ret_q        <= ret_d;
    end
  end

  // Hold register: keeps the last fetched instruction between CPU returns.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: this is a single word observable on cpu_data_o, so it is reset; a real storage array would not be.
    if (!rst) begin
      hold_q <= '0;
    end else if (ret_q == RET_CPU) begin
      hold_q <= bus.mem_rdata_i;
    end
  end

  // RAM port: the granted source drives address and data.
  assign sel_addr        = gnt.host ? bus.host_addr_i : bus.cpu_addr_i;
  assign bus.mem_en_o    = gnt.cpu | gnt.host;
  assign bus.mem_we_o    = gnt.host & bus.host_we_i;
  assign bus.mem_addr_o  = sel_addr;
  assign bus.mem_wdata_o = bus.host_wdata_i;

  // CPU side.
  assign bus.cpu_stall_o = bus.cpu_req_i & ~gnt.cpu;
  assign bus.cpu_valid_o = (ret_q == RET_CPU);
  assign bus.cpu_data_o  = bus.cpu_valid_o ? bus.mem_rdata_i : hold_q;

  // Host side.
  assign bus.host_ack_o    = gnt.host;
  assign bus.host_locked_o = (state_q == PARB_LOCKED);
  assign bus.host_rvalid_o = (ret_q == RET_HOST);
  assign bus.host_rdata_o  = bus.mem_rdata_i;

  // Structural invariants.
  a_one_grant : assert property (@(posedge clk) disable iff (!rst) !(gnt.cpu && gnt.host));
  a_no_cpu_when_owned : assert property (@(posedge clk) disable iff (!rst)
    (state_q != PARB_RUN) |-> !gnt.cpu);

endmodule
